pcie_tx_os_sched: RTL and testbench



---
 rtl/pcie_tx_os_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pcie_tx_os_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_os_sched.sv
// ---------------------------------------------------------------------------
// pcie_tx_os_sched
//
// Transmit-side symbol scheduler between the MAC frame interface and the PHY
// lane encoder. Once a lane is detected it sends TS1_COUNT TS1 ordered sets
// (COM + 15 x D10.2). It then passes MAC symbols through. While in data mode
// it preempts the MAC every SKP_INTERVAL cycles to insert a SKP ordered set
// (COM + 3 x SKP). The output is a single registered valid/ready stage that
// feeds the 8b/10b encoder and carries a K-symbol flag.
//
// Optional feature macro: PCIE_TX_SCHED_IDLE_EN
//   When defined, a data-mode cycle with no MAC symbol loads a logical idle
//   symbol (8'h00, k=0). The output is then valid continuously in data mode.
//   When undefined, phy_data_valid_o drops to 0 in that case.
//
// Ports:
//   clk_i                  clock
//   rst_i                  synchronous active-high reset
//   lane_detected_i        receiver/lane present; when low, link drops to IDLE
//   mac_data_frame_i       MAC data symbol
//   mac_data_frame_valid_i MAC symbol valid
//   mac_data_frame_ready_o scheduler accepts MAC symbol this cycle
//                          (combinational on phy_data_ready_i)
//   phy_data_o             symbol to encoder
//   phy_data_k_o           symbol is a K-code
//   phy_data_valid_o       output symbol valid
//   phy_data_ready_i       encoder accepts symbol
//   link_up_o              scheduler is in data mode (DATA or SKP)
// ---------------------------------------------------------------------------
module pcie_tx_os_sched #(
  parameter int MAC_FRAME_WIDTH = 8,
  parameter int TS1_COUNT       = 8,
  parameter int SKP_INTERVAL    = 1180
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       lane_detected_i,
  input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
  input  logic                       mac_data_frame_valid_i,
  output logic                       mac_data_frame_ready_o,
  output logic [7:0]                 phy_data_o,
  output logic                       phy_data_k_o,
  output logic                       phy_data_valid_o,
  input  logic                       phy_data_ready_i,
  output logic                       link_up_o
);

  // Elaboration-time parameter checks
  if (MAC_FRAME_WIDTH != 8) begin : g_bad_width
    $error("pcie_tx_os_sched: MAC_FRAME_WIDTH must be 8");
  end
  if (TS1_COUNT < 1) begin : g_bad_ts1
    $error("pcie_tx_os_sched: TS1_COUNT must be >= 1");
  end
  if (SKP_INTERVAL < 8) begin : g_bad_skp
    $error("pcie_tx_os_sched: SKP_INTERVAL must be >= 8");
  end

  localparam logic [7:0] SYM_COM      = 8'hBC;  // K28.5
  localparam logic [7:0] SYM_SKP      = 8'h1C;  // K28.0
  localparam logic [7:0] SYM_TS1_FILL = 8'h4A;  // D10.2
  localparam logic [7:0] SYM_IDLE     = 8'h00;

  localparam int TS_W  = (TS1_COUNT > 1) ? $clog2(TS1_COUNT) : 1;
  localparam int TMR_W = $clog2(SKP_INTERVAL);

  localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(TS1_COUNT - 1);
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1'b1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SKP_INTERVAL - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2,
    ST_SKP   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       sym_idx_r, sym_idx_s;
  logic [TS_W-1:0]  ts_cnt_r, ts_cnt_s;
  logic [TMR_W-1:0] skp_timer_r;
  logic             skp_pending_r;
  logic [7:0]       data_r;
  logic             k_r;
  logic             valid_r;
  logic             link_up_r;

  logic             slot_free_s;
  logic             mac_ready_s;
  logic             load_s;
  logic [7:0]       load_data_s;
  logic             load_k_s;
  logic             skp_done_s;
  logic             flush_s;

  // Output slot availability and MAC back-pressure; ready uses the registered
  // pending flag so a MAC symbol can never race a freshly raised SKP request.
  always_comb begin
    slot_free_s = !valid_r || phy_data_ready_i;
    mac_ready_s = (state_r == ST_DATA) && slot_free_s && !skp_pending_r;
  end

  // Next-state, counter and output-load decode
  always_comb begin
    state_s     = state_r;
    sym_idx_s   = sym_idx_r;
    ts_cnt_s    = ts_cnt_r;
    load_s      = 1'b0;
    load_data_s = SYM_IDLE;
    load_k_s    = 1'b0;
    skp_done_s  = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lane_detected_i) begin
          state_s   = ST_TRAIN;
          sym_idx_s = 4'd0;
          ts_cnt_s  = {TS_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TRAIN: begin
        if (!lane_detected_i) begin
          flush_s = 1'b1;
        end else if (slot_free_s) begin
          load_s = 1'b1;
          if (sym_idx_r == 4'd0) begin
            load_data_s = SYM_COM;
            load_k_s    = 1'b1;
          end else begin
            load_data_s = SYM_TS1_FILL;
            load_k_s    = 1'b0;
          end
          if (sym_idx_r == 4'd15) begin
            sym_idx_s = 4'd0;
            if (ts_cnt_r == TS_LAST) begin
              state_s  = ST_DATA;
              ts_cnt_s = {TS_W{1'b0}};
            end else begin
              ts_cnt_s = ts_cnt_r + TS_ONE;
            end
          end else begin
            sym_idx_s = sym_idx_r + 4'd1;
          end
        end else begin
          state_s = ST_TRAIN;
        end
      end
      ST_DATA: begin
        if (!lane_detected_i) begin
          flush_s = 1'b1;
        end else if (skp_pending_r && slot_free_s) begin
          // COM of the SKP set goes out now; SKP state sends the 3 SKPs
          state_s     = ST_SKP;
          sym_idx_s   = 4'd0;
          load_s      = 1'b1;
          load_data_s = SYM_COM;
          load_k_s    = 1'b1;
        end else if (mac_ready_s && mac_data_frame_valid_i) begin
          load_s      = 1'b1;
          load_data_s = mac_data_frame_i;
          load_k_s    = 1'b0;
        end else if (slot_free_s) begin
`ifdef PCIE_TX_SCHED_IDLE_EN
          load_s      = 1'b1;
          load_data_s = SYM_IDLE;
          load_k_s    = 1'b0;
`else
          load_s      = 1'b0;
`endif
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_SKP: begin
        if (!lane_detected_i) begin
          flush_s = 1'b1;
        end else if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = SYM_SKP;
          load_k_s    = 1'b1;
          if (sym_idx_r == 4'd2) begin
            state_s    = ST_DATA;
            sym_idx_s  = 4'd0;
            skp_done_s = 1'b1;
          end else begin
            sym_idx_s = sym_idx_r + 4'd1;
          end
        end else begin
          state_s = ST_SKP;
        end
      end
      default: begin
        flush_s = 1'b1;
      end
    endcase
    // Lane loss abandons any ordered set in progress
    if (flush_s) begin
      state_s   = ST_IDLE;
      sym_idx_s = 4'd0;
      ts_cnt_s  = {TS_W{1'b0}};
      load_s    = 1'b0;
    end else begin
      flush_s = 1'b0;
    end
  end

  // State and ordered-set counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      sym_idx_r <= 4'd0;
      ts_cnt_r  <= {TS_W{1'b0}};
    end else begin
      state_r   <= state_s;
      sym_idx_r <= sym_idx_s;
      ts_cnt_r  <= ts_cnt_s;
    end
  end

  // Registered output stage: load, hold under back-pressure, or go empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r    <= 8'h00;
      k_r       <= 1'b0;
      valid_r   <= 1'b0;
      link_up_r <= 1'b0;
    end else begin
      link_up_r <= (state_s == ST_DATA) || (state_s == ST_SKP);
      if (flush_s) begin
        valid_r <= 1'b0;
      end else if (load_s) begin
        data_r  <= load_data_s;
        k_r     <= load_k_s;
        valid_r <= 1'b1;
      end else if (slot_free_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  // SKP interval timer; a wrap while a request is still pending does not
  // queue a second SKP, and a wrap wins over a same-cycle completion.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_s) begin
      skp_timer_r   <= {TMR_W{1'b0}};
      skp_pending_r <= 1'b0;
    end else if (link_up_r) begin
      if (skp_timer_r == TMR_LAST) begin
        skp_timer_r   <= {TMR_W{1'b0}};
        skp_pending_r <= 1'b1;
      end else begin
        skp_timer_r <= skp_timer_r + TMR_ONE;
        if (skp_done_s) begin
          skp_pending_r <= 1'b0;
        end
      end
    end
  end

  assign mac_data_frame_ready_o = mac_ready_s;
  assign phy_data_o             = data_r;
  assign phy_data_k_o           = k_r;
  assign phy_data_valid_o       = valid_r;
  assign link_up_o              = link_up_r;

endmodule

// File: tb/tb_pcie_tx_os_sched.sv
// ---------------------------------------------------------------------------
// tb_pcie_tx_os_sched
//
// Self-checking bench for pcie_tx_os_sched with TS1_COUNT=2, SKP_INTERVAL=16.
// The reference model works from the link-level rules: the TS1 symbol
// pattern, a data-mode cycle index that places SKP windows every 16 cycles,
// and a scoreboard of accepted MAC symbols matched against the accepted
// output stream.
// ---------------------------------------------------------------------------
module tb_pcie_tx_os_sched;

  localparam int TS1_N   = 2;
  localparam int SKP_INT = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       lane;
  logic [7:0] mac_data;
  logic       mac_valid;
  logic       mac_ready;
  logic [7:0] phy_data;
  logic       phy_k;
  logic       phy_valid;
  logic       phy_ready;
  logic       link_up;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcie_tx_os_sched #(
    .MAC_FRAME_WIDTH(8),
    .TS1_COUNT      (TS1_N),
    .SKP_INTERVAL   (SKP_INT)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .lane_detected_i       (lane),
    .mac_data_frame_i      (mac_data),
    .mac_data_frame_valid_i(mac_valid),
    .mac_data_frame_ready_o(mac_ready),
    .phy_data_o            (phy_data),
    .phy_data_k_o          (phy_k),
    .phy_data_valid_o      (phy_valid),
    .phy_data_ready_i      (phy_ready),
    .link_up_o             (link_up)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    lane      = 1'b0;
    mac_valid = 1'b0;
    mac_data  = 8'h00;
    phy_ready = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i     = 1'b1;
    lane      = 1'b0;
    mac_valid = 1'b0;
    mac_data  = 8'h00;
    phy_ready = 1'b1;
    repeat (3) step();
    n_cmp++; if (phy_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", phy_valid); end
    n_cmp++; if (phy_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", phy_data); end
    n_cmp++; if (phy_k !== 1'b0) begin n_bad++; $display("FAIL reset_k: got %b expected 0", phy_k); end
    n_cmp++; if (link_up !== 1'b0) begin n_bad++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
    n_cmp++; if (mac_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mac_ready: got %b expected 0", mac_ready); end
    rst_i = 1'b0;
    repeat (3) step();
    n_cmp++; if (phy_valid !== 1'b0 || link_up !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_lane: got valid=%b link_up=%b expected 0/0", phy_valid, link_up);
    end
  endtask

  // Raises lane and checks the full training sequence; returns on the cycle
  // link_up first rises, which is data-mode cycle 0.
  task automatic train_and_check(input string tag);
    int   got;
    bit   done;
    logic [8:0] exp_sym;
    got  = 0;
    done = 1'b0;
    lane = 1'b1;
    phy_ready = 1'b1;
    mac_valid = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (phy_valid) begin
        if (got < 16 * TS1_N) begin
          exp_sym = (got % 16 == 0) ? {1'b1, 8'hBC} : {1'b0, 8'h4A};
          n_cmp++;
          if ({phy_k, phy_data} !== exp_sym) begin
            n_bad++; $display("FAIL %s_ts1_sym%0d: got %h expected %h", tag, got, {phy_k, phy_data}, exp_sym);
          end
        end
        got++;
      end
      if (link_up) begin
        done = 1'b1;
        n_cmp++;
        if (got !== 16 * TS1_N) begin
          n_bad++; $display("FAIL %s_ts1_count: got %0d expected %0d at link_up", tag, got, 16 * TS1_N);
        end
      end else begin
        n_cmp++;
        if (mac_ready !== 1'b0) begin
          n_bad++; $display("FAIL %s_train_mac_ready: got %b expected 0", tag, mac_ready);
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL %s_link_up_timeout: got no link_up expected link_up within 60 cycles", tag);
    end
  endtask

  // Data mode with encoder always ready. mode 0: constant AB stream,
  // mode 1: random valid/data, mode 2: MAC idle.
  task automatic test_data_mode(input int mode, input string tag);
    bit         prev_acc;
    logic [7:0] prev_d;
    bit         exp_v;
    logic [8:0] exp_sym;
    bit         exp_rdy;
    int         w;
    prev_acc = 1'b0;
    prev_d   = 8'h00;
    for (int t = 0; t < 80; t++) begin
      if (t > 0) step();
      if (t >= 1) begin
        w = t - 1;
        if (w >= SKP_INT && (w % SKP_INT) < 4) begin
          exp_v   = 1'b1;
          exp_sym = ((w % SKP_INT) == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h1C};
        end else if (prev_acc) begin
          exp_v   = 1'b1;
          exp_sym = {1'b0, prev_d};
        end else begin
`ifdef PCIE_TX_SCHED_IDLE_EN
          exp_v   = 1'b1;
`else
          exp_v   = 1'b0;
`endif
          exp_sym = {1'b0, 8'h00};
        end
        n_cmp++;
        if (phy_valid !== exp_v) begin
          n_bad++; $display("FAIL %s_valid_t%0d: got %b expected %b", tag, t, phy_valid, exp_v);
        end else if (exp_v) begin
          n_cmp++;
          if ({phy_k, phy_data} !== exp_sym) begin
            n_bad++; $display("FAIL %s_sym_t%0d: got %h expected %h", tag, t, {phy_k, phy_data}, exp_sym);
          end
        end
      end
      n_cmp++;
      if (link_up !== 1'b1) begin
        n_bad++; $display("FAIL %s_link_up_t%0d: got %b expected 1", tag, t, link_up);
      end
      case (mode)
        0: begin mac_valid = 1'b1; mac_data = 8'hAB; end
        1: begin mac_valid = ($urandom % 4) != 0; mac_data = 8'($urandom); end
        default: begin mac_valid = 1'b0; mac_data = 8'($urandom); end
      endcase
      #1;
      exp_rdy = !(t >= SKP_INT && (t % SKP_INT) < 4);
      n_cmp++;
      if (mac_ready !== exp_rdy) begin
        n_bad++; $display("FAIL %s_mac_ready_t%0d: got %b expected %b", tag, t, mac_ready, exp_rdy);
      end
      prev_acc = mac_valid && exp_rdy;
      prev_d   = mac_data;
    end
    mac_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [8:0] acc_q[$];
    logic [7:0] mac_q[$];
    logic [9:0] snap;
    logic [8:0] s;
    logic [7:0] exp_d;
    int stall_left;
    int stalls_done;
    bit seen_lu;
    int i;
    int skp_cnt;
    stall_left  = 0;
    stalls_done = 0;
    seen_lu     = 1'b0;
    snap        = 10'h000;
    do_reset();
    lane = 1'b1;
    for (int c = 0; c < 170; c++) begin
      step();
      if (stall_left > 0) begin
        n_cmp++;
        if ({phy_valid, phy_k, phy_data} !== snap) begin
          n_bad++; $display("FAIL stall_hold_c%0d: got %h expected %h", c, {phy_valid, phy_k, phy_data}, snap);
        end
      end
      if (link_up) seen_lu = 1'b1;
      if (stall_left == 0) begin
        if ((stalls_done == 0 && c == 12) ||
            (stalls_done == 1 && seen_lu && phy_valid && phy_k && phy_data == 8'h1C)) begin
          stall_left = 5;
          stalls_done++;
          snap = {phy_valid, phy_k, phy_data};
        end
      end
      phy_ready = (stall_left == 0);
      mac_valid = seen_lu && (c < 155);
      mac_data  = 8'(1 + ($urandom % 255));
      #1;
      if (stall_left > 0) begin
        n_cmp++;
        if (mac_ready !== 1'b0) begin
          n_bad++; $display("FAIL stall_mac_ready_c%0d: got %b expected 0", c, mac_ready);
        end
      end
      if (phy_valid && phy_ready) acc_q.push_back({phy_k, phy_data});
      if (mac_valid && mac_ready) mac_q.push_back(mac_data);
      if (stall_left > 0) stall_left--;
    end
    phy_ready = 1'b1;
    mac_valid = 1'b0;
    n_cmp++;
    if (stalls_done !== 2) begin
      n_bad++; $display("FAIL stall_skp_found: got %0d stalls expected 2", stalls_done);
    end
    n_cmp++;
    if (acc_q.size() < 32) begin
      n_bad++; $display("FAIL stall_stream_len: got %0d expected at least 32", acc_q.size());
    end else begin
      for (int j = 0; j < 32; j++) begin
        s = (j % 16 == 0) ? {1'b1, 8'hBC} : {1'b0, 8'h4A};
        n_cmp++;
        if (acc_q[j] !== s) begin
          n_bad++; $display("FAIL stall_ts1_sym%0d: got %h expected %h", j, acc_q[j], s);
        end
      end
    end
    i = 32;
    skp_cnt = 0;
    while (i < acc_q.size()) begin
      s = acc_q[i];
      if (s == {1'b1, 8'hBC}) begin
        for (int j = 1; j < 4; j++) begin
          if (i + j < acc_q.size()) begin
            n_cmp++;
            if (acc_q[i + j] !== {1'b1, 8'h1C}) begin
              n_bad++; $display("FAIL stall_skp_sym%0d: got %h expected 11c", i + j, acc_q[i + j]);
            end
          end
        end
        skp_cnt++;
        i += 4;
      end else begin
`ifdef PCIE_TX_SCHED_IDLE_EN
        if (s == 9'h000) begin
          i++;
          continue;
        end
`endif
        n_cmp++;
        if (mac_q.size() == 0) begin
          n_bad++; $display("FAIL stall_extra_sym%0d: got %h expected none", i, s);
        end else begin
          exp_d = mac_q.pop_front();
          if (s !== {1'b0, exp_d}) begin
            n_bad++; $display("FAIL stall_mac_sym%0d: got %h expected %h", i, s, {1'b0, exp_d});
          end
        end
        i++;
      end
    end
    n_cmp++;
    if (mac_q.size() != 0) begin
      n_bad++; $display("FAIL stall_mac_lost: got %0d unsent expected 0", mac_q.size());
    end
    n_cmp++;
    if (skp_cnt < 2) begin
      n_bad++; $display("FAIL stall_skp_count: got %0d expected >= 2", skp_cnt);
    end
  endtask

  task automatic test_lane_loss();
    do_reset();
    train_and_check("ll_train");
    mac_valid = 1'b1;
    mac_data  = 8'hAB;
    repeat (5) step();
    lane      = 1'b0;
    step();
    n_cmp++;
    if (phy_valid !== 1'b0) begin n_bad++; $display("FAIL lane_loss_valid: got %b expected 0", phy_valid); end
    n_cmp++;
    if (link_up !== 1'b0) begin n_bad++; $display("FAIL lane_loss_link_up: got %b expected 0", link_up); end
    n_cmp++;
    if (mac_ready !== 1'b0) begin n_bad++; $display("FAIL lane_loss_mac_ready: got %b expected 0", mac_ready); end
    mac_valid = 1'b0;
    repeat (3) step();
    train_and_check("ll_retrain");
    test_data_mode(0, "ll_resume");
  endtask

  task automatic test_reset_mid();
    do_reset();
    train_and_check("rm_train");
    mac_valid = 1'b1;
    mac_data  = 8'h5A;
    repeat (4) step();
    rst_i = 1'b1;
    step();
    n_cmp++;
    if ({phy_valid, phy_k, phy_data, link_up, mac_ready} !== 12'h000) begin
      n_bad++; $display("FAIL reset_mid: got v=%b k=%b d=%h lu=%b rdy=%b expected all 0",
                        phy_valid, phy_k, phy_data, link_up, mac_ready);
    end
    rst_i     = 1'b0;
    mac_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    do_reset();
    train_and_check("train");
    test_data_mode(0, "stream_ab");
    do_reset();
    train_and_check("train2");
    test_data_mode(1, "stream_rand");
    do_reset();
    train_and_check("train3");
    test_data_mode(2, "mac_idle");
    test_stall();
    test_lane_loss();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
